squeeze_weight_sequencer: RTL and testbench
===========================================

# squeeze_weight_sequencer

Address sequencer and stream controller directly upstream of the fire2 squeeze 16-lane weight ROM array. Drives the shared ROM address so that all 16 lanes step through `0..DEPTH-1` once per pass, for `NPASS` passes. Produces `w_valid`, `w_last` and `w_pass_last`, aligned with the ROM's registered 1-cycle output. The downstream MAC array applies back-pressure through `w_ready` without losing or duplicating a weight word.

## Interface
**Parameters**
- `ADDR`, 10: ROM address width.
- `DEPTH`, 576: weight words per lane per pass. Elaboration error if `DEPTH > 2**ADDR` or `DEPTH < 2`.
- `NPASS`, 4: passes per run, one per pixel tile. Elaboration error if `< 1`.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: run request; sampled only in IDLE.
- `w_ready`, in, 1: consumer accepts the current beat.
- `rom_addr`, out, `ADDR`: address to the ROM array (combinational).
- `w_valid`, out, 1: `rom_out[0..15]` holds a valid beat this cycle.
- `w_last`, out, 1: current beat is address `DEPTH-1`.
- `w_pass_last`, out, 1: current beat is the final word of the final pass.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, RUN, DRAIN, held in registered `state`.
- IDLE:
  - `start=1` → RUN.
  - `addr_cnt` and `pass_cnt` are cleared to 0.
- RUN:
  - `issue = !(w_valid && !w_ready)`.
  - On `issue`, `rom_addr = addr_cnt`; the address is captured into `last_addr` and `issued_q` is set to 1.
  - `addr_cnt` wraps `DEPTH-1 → 0` and increments `pass_cnt`.
  - Issuing `addr_cnt = DEPTH-1` while `pass_cnt = NPASS-1` → DRAIN.
- Stall (`!issue`):
  - `rom_addr = last_addr`, so the ROM re-reads the word on display and `rom_out` stays stable.
  - Counters hold.
- Beat tags: `w_last` and `w_pass_last` are registered alongside `issued_q` from the issued address and pass.
- Beat pipeline:
  - `w_valid` is set when a word is issued.
  - `w_valid` clears when the beat is accepted (`w_valid && w_ready`) and no new word is issued.
  - Invariant: while `w_valid=1`, the displayed beat is `last_addr`.
- DRAIN:
  - No issue; `rom_addr = last_addr`.
  - Acceptance of the beat with `w_pass_last=1` → IDLE, and `done=1` for exactly the next cycle.
- `start` outside IDLE is ignored (no queueing).
- `rst` at any time:
  - Aborts immediately: state IDLE, counters 0, `w_valid`, `w_last`, `w_pass_last` and `done` cleared.
  - An in-flight beat is discarded.

## Timing
- Reset values: `rom_addr=0`, `w_valid=0`, `w_last=0`, `w_pass_last=0`, `busy=0`, `done=0`.
- `start` sampled at edge E → `busy=1` and first issue (`rom_addr=0`) in cycle E+1 → first `w_valid` in cycle E+2.
- With `w_ready` held high:
  - One beat per cycle, no bubbles, including across pass boundaries.
  - Total `DEPTH*NPASS` beats.
  - `done` rises 1 cycle after the final beat's valid cycle.
- `w_ready` low for N cycles: the same beat is presented N+1 cycles with identical `rom_out`.
- `rom_addr` depends combinationally on `w_ready`; the consumer must drive `w_ready` from registers.
- A new `start` may be sampled in the same cycle `done=1`; the run begins as from IDLE.

## Structure
- Shared package `fire_seq_pkg`: state enum `seq_state_t` (IDLE, RUN, DRAIN) and the beat-tag struct (`last`, `pass_last`). All fire-layer sequencers reuse both.
- One natural sub-module: `wrap_counter`, parameterised by width and modulus, with `en`, `clr` and a `wrap` flag. It is instantiated twice, once for the address and once for the pass counter.
- Everything else is flat in `squeeze_weight_sequencer`.

## Test plan
- Reset mid-RUN at beat 100: next cycle `w_valid=0`, `busy=0`. A fresh `start` restarts at `rom_addr=0`.
- Free flow, `DEPTH=576`, `NPASS=4`, `w_ready=1`: exactly 2304 beats with contiguous addresses 0..575 ×4. `w_last` on beats 575, 1151, 1727 and 2303; `w_pass_last` only on 2303. `done` one cycle after beat 2303.
- `w_ready` low for 3 cycles while presenting address 37: `rom_addr` stays 37, `rom_out` is identical for 4 cycles, and address 38 follows with no skip or duplicate.
- Random 50% `w_ready`, scoreboard against a ROM model: every `(pass, addr)` is received exactly once, in order, with matching data for all 16 lanes.
- `start` pulsed in RUN and DRAIN: ignored, beat count unchanged. `start` in the `done` cycle: the second run begins, with first `w_valid` 2 cycles later.
- `NPASS=1`, `DEPTH=2`: beats at address 0 and 1. `w_last=w_pass_last=1` on the second beat; `done` follows.

Source files
------------

// File: rtl/fire_seq_pkg.sv
// ---------------------------------------------------------------------------
// fire_seq_pkg
//   Types shared by the fire-layer weight sequencers.
//   seq_state_t : sequencer FSM state (IDLE, RUN, DRAIN)
//   beat_tag_t  : per-beat side tags registered alongside the ROM read
//   clog2_min1  : counter width helper that never returns 0
// ---------------------------------------------------------------------------
package fire_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic last;       // beat is the final address of a pass
        logic pass_last;  // beat is the final word of the final pass
    } beat_tag_t;

    localparam int LANES = 16;

    // A modulus of 1 or 2 still needs a 1-bit register.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/squeeze_weight_sequencer_if.sv
// ---------------------------------------------------------------------------
// squeeze_weight_sequencer_if
//   Bundle between the squeeze weight sequencer and its consumer/ROM.
//   master : sequencer side (drives rom_addr, w_valid, tags, busy, done,
//            state_dbg; receives start, w_ready)
//   slave  : consumer side (mirror image)
//
//   Handshake: a beat transfers on every rising edge where w_valid and
//   w_ready are both 1. While w_valid=1 and w_ready=0 the beat, its tags and
//   rom_out stay unchanged until accepted. w_valid never depends on w_ready;
//   rom_addr does, so w_ready must come straight from consumer registers.
// ---------------------------------------------------------------------------
interface squeeze_weight_sequencer_if
    import fire_seq_pkg::*;
#(
    parameter int ADDR = 10
);
    logic            start;
    logic            w_ready;
    logic [ADDR-1:0] rom_addr;
    logic            w_valid;
    logic            w_last;
    logic            w_pass_last;
    logic            busy;
    logic            done;
    seq_state_t      state_dbg;

    modport master (
        input  start, w_ready,
        output rom_addr, w_valid, w_last, w_pass_last, busy, done, state_dbg
    );

    modport slave (
        output start, w_ready,
        input  rom_addr, w_valid, w_last, w_pass_last, busy, done, state_dbg
    );

endinterface

// File: rtl/wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
//   Modulo-MOD up counter.
//   clk, rst : clock, synchronous active-high reset
//   en       : advance by one (wraps MOD-1 -> 0)
//   clr      : synchronous clear, wins over en
//   cnt      : current count
//   at_max   : cnt == MOD-1
//   wrap     : en && at_max (the count wraps on this edge)
// ---------------------------------------------------------------------------
module wrap_counter #(
    parameter int W   = 4,
    parameter int MOD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max,
    output logic         wrap
);

    if (MOD < 1 || MOD > (1 << W)) begin : g_bad_mod
        $error("wrap_counter: MOD must be in 1..2**W");
    end

    always_comb begin
        at_max = (cnt == W'(MOD - 1));
        wrap   = en && at_max;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_max ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/squeeze_weight_sequencer.sv
// ---------------------------------------------------------------------------
// squeeze_weight_sequencer
//   Address sequencer for the fire2 squeeze 16-lane weight ROM array. Walks
//   the shared ROM address 0..DEPTH-1 for NPASS passes and tags each beat so
//   that w_valid/w_last/w_pass_last line up with the ROM's registered output.
//   clk, rst : clock, synchronous active-high reset
//   sif      : master side of squeeze_weight_sequencer_if
//              start, w_ready in; rom_addr, w_valid, w_last, w_pass_last,
//              busy, done, state_dbg out
// ---------------------------------------------------------------------------
module squeeze_weight_sequencer
    import fire_seq_pkg::*;
#(
    parameter int ADDR  = 10,
    parameter int DEPTH = 576,
    parameter int NPASS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    squeeze_weight_sequencer_if.master    sif
);

    if (DEPTH < 2 || DEPTH > (1 << ADDR)) begin : g_bad_depth
        $error("squeeze_weight_sequencer: DEPTH must be in 2..2**ADDR");
    end
    if (NPASS < 1) begin : g_bad_npass
        $error("squeeze_weight_sequencer: NPASS must be at least 1");
    end

    localparam int PW = clog2_min1(NPASS);

    seq_state_t      state_q, state_d;
    logic [ADDR-1:0] last_addr_q;
    logic            w_valid_q;
    beat_tag_t       tag_q;
    logic            done_q;

    logic            issue;
    logic            final_accept;
    logic            in_idle;

    logic [ADDR-1:0] addr_cnt;
    logic            addr_at_max;
    logic            addr_wrap;
    logic [PW-1:0]   pass_cnt;
    logic            pass_at_max;
    logic            pass_wrap;

    // Counters are parked at 0 whenever the sequencer is idle so every run
    // starts from address 0 of pass 0.
    wrap_counter #(.W(ADDR), .MOD(DEPTH)) u_addr_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (issue),
        .clr    (in_idle),
        .cnt    (addr_cnt),
        .at_max (addr_at_max),
        .wrap   (addr_wrap)
    );

    wrap_counter #(.W(PW), .MOD(NPASS)) u_pass_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (addr_wrap),
        .clr    (in_idle),
        .cnt    (pass_cnt),
        .at_max (pass_at_max),
        .wrap   (pass_wrap)
    );

    always_comb begin
        in_idle      = (state_q == IDLE);
        // A new read may go out unless the displayed beat is being held.
        issue        = (state_q == RUN) && !(w_valid_q && !sif.w_ready);
        final_accept = w_valid_q && sif.w_ready && tag_q.pass_last;

        state_d = state_q;
        case (state_q)
            IDLE:    if (sif.start)           state_d = RUN;
            RUN:     if (issue && pass_wrap)  state_d = DRAIN;
            DRAIN:   if (final_accept)        state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_addr_q <= '0;
            w_valid_q   <= 1'b0;
            tag_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DRAIN) && final_accept;
            if (issue) begin
                last_addr_q     <= addr_cnt;
                w_valid_q       <= 1'b1;
                tag_q.last      <= addr_at_max;
                tag_q.pass_last <= addr_at_max && pass_at_max;
            end else if (w_valid_q && sif.w_ready) begin
                w_valid_q <= 1'b0;
            end
        end
    end

    // On a stall the ROM re-reads the displayed address, keeping rom_out
    // stable without a holding register on the 16 lanes.
    always_comb begin
        sif.rom_addr    = issue ? addr_cnt : last_addr_q;
        sif.w_valid     = w_valid_q;
        sif.w_last      = w_valid_q && tag_q.last;
        sif.w_pass_last = w_valid_q && tag_q.pass_last;
        sif.busy        = (state_q != IDLE);
        sif.done        = done_q;
        sif.state_dbg   = state_q;
    end

endmodule

// File: tb/tb_squeeze_weight_sequencer.sv
module tb_squeeze_weight_sequencer;
  import fire_seq_pkg::*;

  localparam int ADDR  = 10;
  localparam int DEPTH = 576;
  localparam int NPASS = 4;
  localparam int TOTAL = DEPTH * NPASS;
  localparam int DW    = 16;
  localparam int NL    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  squeeze_weight_sequencer_if #(.ADDR(ADDR)) sif ();
  squeeze_weight_sequencer_if #(.ADDR(ADDR)) sif2 ();

  squeeze_weight_sequencer #(.ADDR(ADDR), .DEPTH(DEPTH), .NPASS(NPASS)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  squeeze_weight_sequencer #(.ADDR(ADDR), .DEPTH(2), .NPASS(1)) dut2 (
    .clk (clk),
    .rst (rst),
    .sif (sif2)
  );

  // ---------------- ROM model (registered, 1-cycle) ----------------
  function automatic logic [DW-1:0] rom_word(input logic [ADDR-1:0] a, input int lane);
    logic [31:0] v;
    v = 32'(a) * 32'd37 + 32'(lane) * 32'd1013 + 32'd5;
    return v[DW-1:0] ^ DW'(lane << 4);
  endfunction

  logic [DW-1:0] rom_out [NL];
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) rom_out[l] <= rom_word(sif.rom_addr, l);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [ADDR+1:0] exp_q[$];   // {pass_last, last, addr}
  int run_beat   = 0;
  int first_cyc  = 0;
  int last_cyc   = 0;
  int pres_cnt   = 0;
  int pres37     = 0;
  int ready_mode = 0;          // 0: always ready, 1: random, 2: stall on beat 37
  int stall_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_run();
    for (int p = 0; p < NPASS; p++)
      for (int a = 0; a < DEPTH; a++)
        exp_q.push_back({(p == NPASS - 1 && a == DEPTH - 1), (a == DEPTH - 1), ADDR'(a)});
  endtask

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: sif.w_ready = 1'($urandom_range(0, 1));
      2: begin
        if (sif.w_valid && run_beat == 37 && stall_left > 0) begin
          sif.w_ready = 1'b0;
          stall_left--;
        end else begin
          sif.w_ready = 1'b1;
        end
      end
      default: sif.w_ready = 1'b1;
    endcase
  end

  // ---------------- monitor ----------------
  logic          exp_done = 1'b0;
  logic          stalled  = 1'b0;
  logic [DW-1:0] snap [NL];
  logic [ADDR+1:0] e;
  int            ls;

  always @(negedge clk) begin
    if (rst) begin
      exp_done = 1'b0;
      stalled  = 1'b0;
      pres_cnt = 0;
    end else begin
      if (sif.done || exp_done) check("done_pulse", sif.done, exp_done);
      exp_done = 1'b0;
      if (stalled) begin
        check("stall_valid", sif.w_valid, 1'b1);
        ls = 0;
        for (int l = NL - 1; l >= 0; l--) if (rom_out[l] !== snap[l]) ls = l;
        check("stall_hold", rom_out[ls], snap[ls]);
      end
      if (sif.w_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", sif.w_valid, 1'b0);
        end else begin
          e = exp_q[0];
          pres_cnt++;
          ls = 0;
          for (int l = NL - 1; l >= 0; l--)
            if (rom_out[l] !== rom_word(e[ADDR-1:0], l)) ls = l;
          check("beat_data", rom_out[ls], rom_word(e[ADDR-1:0], ls));
          check("beat_tags", {sif.w_pass_last, sif.w_last}, e[ADDR+1:ADDR]);
          if (!sif.w_ready) check("stall_addr", sif.rom_addr, e[ADDR-1:0]);
          if (sif.w_ready) begin
            void'(exp_q.pop_front());
            if (run_beat == 0) first_cyc = cyc;
            if (run_beat == 37) pres37 = pres_cnt;
            pres_cnt = 0;
            run_beat++;
            if (e[ADDR+1]) begin
              exp_done = 1'b1;
              last_cyc = cyc;
            end
          end
        end
      end
      stalled = sif.w_valid && !sif.w_ready;
      for (int l = 0; l < NL; l++) snap[l] = rom_out[l];
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+2: start is sampled by the next edge.
  task automatic start_run();
    push_run();
    run_beat = 0;
    pres37   = 0;
    sif.start = 1'b1;
    @(posedge clk);
    #1 sif.start = 1'b0;
    #1;
    check("start_busy", sif.busy, 1'b1);
    check("first_addr", sif.rom_addr, '0);
    @(posedge clk);
    #2 check("first_valid", sif.w_valid, 1'b1);
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    int n;
    n = 0;
    while (!sif.done && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    done_cyc = cyc;
    if (!sif.done) check("done_timeout", sif.done, 1'b1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (run_beat < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (run_beat < target) check("beat_timeout", 64'(run_beat), 64'(target));
  endtask

  // ---------------- stimulus ----------------
  int dc;
  int n;

  initial begin
    sif.start    = 1'b0;
    sif2.start   = 1'b0;
    sif2.w_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs",
          {sif.rom_addr, sif.w_valid, sif.w_last, sif.w_pass_last, sif.busy, sif.done},
          '0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Free flow: contiguous beats, done one cycle after the final beat.
    ready_mode = 0;
    start_run();
    wait_done(TOTAL + 20, dc);
    check("ff_beat_count", 64'(run_beat), 64'(TOTAL));
    check("ff_no_bubbles", 64'(last_cyc - first_cyc + 1), 64'(TOTAL));
    check("ff_done_latency", 64'(dc), 64'(last_cyc + 1));

    // Restart in the done cycle, with a 3-cycle stall on address 37.
    ready_mode = 2;
    stall_left = 3;
    start_run();
    wait_done(TOTAL + 40, dc);
    check("stall_present_cycles", 64'(pres37), 64'd4);
    check("stall_beat_count", 64'(run_beat), 64'(TOTAL));

    // Random ready; start pulsed in RUN and in DRAIN must be ignored.
    ready_mode = 1;
    start_run();
    wait_beats(500, 4 * TOTAL);
    sif.start = 1'b1;
    @(posedge clk);
    #2 sif.start = 1'b0;
    n = 0;
    while (sif.state_dbg != DRAIN && n < 4 * TOTAL) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("reach_drain", sif.state_dbg, DRAIN);
    sif.start = 1'b1;
    @(posedge clk);
    #2 sif.start = 1'b0;
    wait_done(200, dc);
    check("rand_beat_count", 64'(run_beat), 64'(TOTAL));
    ready_mode = 0;
    repeat (5) @(posedge clk);
    #2;
    check("start_ignored_busy", sif.busy, 1'b0);
    check("start_ignored_queue", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a run, then a fresh run from address 0.
    start_run();
    wait_beats(100, 400);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2;
    check("rst_valid", sif.w_valid, 1'b0);
    check("rst_busy", sif.busy, 1'b0);
    check("rst_done", sif.done, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    start_run();
    wait_done(TOTAL + 20, dc);
    check("rst_rerun_count", 64'(run_beat), 64'(TOTAL));

    // Minimal configuration: DEPTH=2, NPASS=1.
    sif2.start = 1'b1;
    @(posedge clk);
    #1 sif2.start = 1'b0;
    #1;
    check("small_busy", sif2.busy, 1'b1);
    check("small_addr0", sif2.rom_addr, '0);
    @(posedge clk);
    #2;
    check("small_beat0", {sif2.w_valid, sif2.w_last, sif2.w_pass_last}, 3'b100);
    check("small_addr1", sif2.rom_addr, ADDR'(1));
    @(posedge clk);
    #2;
    check("small_beat1", {sif2.w_valid, sif2.w_last, sif2.w_pass_last}, 3'b111);
    check("small_drain", sif2.state_dbg, DRAIN);
    @(posedge clk);
    #2;
    check("small_done", {sif2.done, sif2.w_valid, sif2.busy}, 3'b100);
    @(posedge clk);
    #2;
    check("small_done_pulse", sif2.done, 1'b0);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
